curve25519_arbiter: RTL and testbench
=====================================

Name: curve25519_arbiter

Overview:
- Shares a single curve25519 scalar-multiplication core among R independent requesters.
- Accepts requests one at a time using round-robin arbitration.
- Sequences the core with a one-cycle start pulse, waits for done (bounded by a watchdog), then returns the result plus the requester id on one shared response channel.
- Sits between client engines (key exchange, signing) and the core instance.

Parameters:
- R, default 4: number of requesters (2..16).
- TIMEOUT, default 4096: maximum cycles to wait for core_done before aborting.
- IDW, default $clog2(R): width of the requester id.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  R  per-requester request valid.
- req_ready  out  R  per-requester accept; one-hot or zero.
- req_n  in  R*255  scalars; requester k uses bits [255k+254:255k].
- req_q  in  R*255  u-coordinates, same packing as req_n.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  IDW  index of the requester that is answered.
- rsp_out  out  255  result u-coordinate.
- rsp_err  out  1  1 = watchdog timeout; rsp_out is then 0.
- core_start  out  1  one-cycle start pulse to the core.
- core_n  out  255  scalar to the core; held stable from start until leaving WAIT.
- core_q  out  255  point to the core; held like core_n.
- core_done  in  1  core completion pulse; core_out valid in the same cycle.
- core_out  in  255  core result.
- core_abort  out  1  one-cycle pulse on timeout; system ORs it into the core's reset.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, START, WAIT, RESP. Reset enters IDLE.
- Reset values:
  - Outputs: req_ready=0, rsp_valid=0, rsp_id=0, rsp_out=0, rsp_err=0, core_start=0, core_n=0, core_q=0, core_abort=0, busy=0.
  - last_grant=R-1, so requester 0 has first priority.
- IDLE:
  - If any req_valid is high, grant g = first set bit searching upward from last_grant+1 with wrap-around.
  - req_ready[g]=1 combinationally in this cycle; the handshake completes in the same cycle.
  - Latch req_n[g]→core_n, req_q[g]→core_q, g→rsp_id, g→last_grant. Go to START.
  - req_ready is 0 in every other state. A requester that drops valid before being granted loses nothing.
- START:
  - core_start=1 for exactly this cycle. Clear the watchdog counter. Go to WAIT.
  - core_done is ignored in this cycle.
- WAIT:
  - On core_done: latch core_out→rsp_out, set rsp_err=0, go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without done: set rsp_out=0, rsp_err=1, pulse core_abort for 1 cycle, go to RESP.
  - If core_done and the timeout coincide, done wins (no error, no abort).
- RESP:
  - rsp_valid=1; rsp_id, rsp_out and rsp_err are held stable.
  - On rsp_ready: go to IDLE, with rsp_valid=0 next cycle.
  - A new grant may occur at the earliest in the cycle after the response handshake.
- core_done is honoured only in WAIT. It is ignored in IDLE, START and RESP (stale or late completions).
- Latency: grant at cycle T → core_start at T+1 → rsp_valid the cycle after core_done. Minimum overhead is 3 cycles beyond core latency.
- Reset asserted mid-operation:
  - Everything returns immediately to reset values, and any in-flight job is dropped.
  - core_start is never left high. core_abort is not pulsed; the core shares the system reset.
- Fairness: with all requesters continuously valid, grants cycle 0,1,2,…,R-1,0,…

Test Plan:
- Single request: requester 2 sends n=0x1234, q=0x5678; mock core returns 0x5678 → rsp_valid with rsp_id=2, rsp_out=0x5678, rsp_err=0. core_start is high exactly 1 cycle, and req_ready[2] is high exactly 1 cycle.
- Round-robin: all 4 req_valid held high, rsp_ready=1 → grant/response order 0,1,2,3,0; no requester is granted twice before all others.
- Basepoint vector: n=0x4000…0000, q=9, real core → rsp_out=0x743bcb585f9990edc2cfc4af84f6ff300729bb5facda28154362cd47a37de52f. core_n and core_q stay stable throughout WAIT.
- Back-pressure: hold rsp_ready=0 for 20 cycles after done → rsp_* stay stable, req_ready stays 0, and a stray core_done pulse during RESP does not change rsp_out.
- Watchdog: TIMEOUT=16, core never asserts done → exactly 16 cycles after leaving START, core_abort pulses once; response has rsp_err=1, rsp_out=0. A late core_done arriving in IDLE is ignored.
- Reset mid-WAIT: assert reset 5 cycles after core_start → all outputs are 0 asynchronously. After release, requester 0 is granted first if valid.

Source files
------------

// File: rtl/curve25519_arbiter.sv
// curve25519_arbiter: round-robin sharing of one curve25519 scalar-mult core
// among R requesters, with start pulse, watchdog abort and a shared response.
//
// Ports:
//   clock, reset            : system clock, async active-high reset
//   req_valid/req_ready     : per-requester handshake (ready is one-hot or 0)
//   req_n/req_q             : packed 255-bit scalars / u-coords per requester
//   rsp_valid/rsp_ready     : shared response handshake
//   rsp_id/rsp_out/rsp_err  : answered requester, result, watchdog flag
//   core_start/core_n/core_q: job launch towards the core
//   core_done/core_out      : core completion and result
//   core_abort              : one-cycle pulse when the watchdog fires
//   busy                    : arbiter is not idle
module curve25519_arbiter #(
    parameter int R       = 4,
    parameter int TIMEOUT = 4096,
    parameter int IDW     = $clog2(R)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [R-1:0]     req_valid,
    output logic [R-1:0]     req_ready,
    input  logic [R*255-1:0] req_n,
    input  logic [R*255-1:0] req_q,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [IDW-1:0]   rsp_id,
    output logic [254:0]     rsp_out,
    output logic             rsp_err,
    output logic             core_start,
    output logic [254:0]     core_n,
    output logic [254:0]     core_q,
    input  logic             core_done,
    input  logic [254:0]     core_out,
    output logic             core_abort,
    output logic             busy
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        RESP
    } state_t;

    state_t         state_q;
    logic [IDW-1:0] last_q;
    logic [CW-1:0]  cnt_q;
    logic [IDW-1:0] rsp_id_q;
    logic [254:0]   rsp_out_q;
    logic           rsp_err_q;
    logic           core_start_q;
    logic           core_abort_q;
    logic [254:0]   core_n_q;
    logic [254:0]   core_q_q;

    logic [IDW-1:0] grant_d;
    logic           any_req_d;

    // Scan downward in distance so the requester closest after last_q wins.
    always_comb begin
        int idx;
        grant_d   = last_q;
        any_req_d = 1'b0;
        idx       = 0;
        for (int i = R; i >= 1; i--) begin
            idx = (int'(last_q) + i) % R;
            if (req_valid[idx]) begin
                grant_d   = IDW'(idx);
                any_req_d = 1'b1;
            end
        end
    end

    // Ready is combinational so the handshake completes in the grant cycle;
    // gated by reset so every output reads 0 while reset is held.
    always_comb begin
        req_ready = '0;
        if (!reset && state_q == IDLE && any_req_d) begin
            req_ready[grant_d] = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_q       <= IDW'(R - 1);
            cnt_q        <= '0;
            rsp_id_q     <= '0;
            rsp_out_q    <= '0;
            rsp_err_q    <= 1'b0;
            core_start_q <= 1'b0;
            core_abort_q <= 1'b0;
            core_n_q     <= '0;
            core_q_q     <= '0;
        end else begin
            core_start_q <= 1'b0;
            core_abort_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (any_req_d) begin
                        core_n_q     <= req_n[int'(grant_d)*255 +: 255];
                        core_q_q     <= req_q[int'(grant_d)*255 +: 255];
                        rsp_id_q     <= grant_d;
                        last_q       <= grant_d;
                        core_start_q <= 1'b1;
                        state_q      <= START;
                    end
                end
                START: begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // done is tested first so a coincident timeout loses
                    if (core_done) begin
                        rsp_out_q <= core_out;
                        rsp_err_q <= 1'b0;
                        state_q   <= RESP;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        rsp_out_q    <= '0;
                        rsp_err_q    <= 1'b1;
                        core_abort_q <= 1'b1;
                        state_q      <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid  = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign rsp_id     = rsp_id_q;
    assign rsp_out    = rsp_out_q;
    assign rsp_err    = rsp_err_q;
    assign core_start = core_start_q;
    assign core_abort = core_abort_q;
    assign core_n     = core_n_q;
    assign core_q     = core_q_q;

endmodule

// File: tb/tb_curve25519_arbiter.sv
// tb_curve25519_arbiter: randomized bench with a transaction-level model of
// the arbiter and a mock core (latency, hangs, stray done pulses).
module tb_curve25519_arbiter;

    localparam int R   = 4;
    localparam int TO  = 16;
    localparam int IDW = 2;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [R-1:0]     req_valid = '0;
    logic [R-1:0]     req_ready;
    logic [R*255-1:0] req_n = '0;
    logic [R*255-1:0] req_q = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [IDW-1:0]   rsp_id;
    logic [254:0]     rsp_out;
    logic             rsp_err;
    logic             core_start;
    logic [254:0]     core_n;
    logic [254:0]     core_q;
    logic             core_done = 1'b0;
    logic [254:0]     core_out = '0;
    logic             core_abort;
    logic             busy;

    always #5 clock = ~clock;

    curve25519_arbiter #(.R(R), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_n(req_n), .req_q(req_q),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_out(rsp_out), .rsp_err(rsp_err),
        .core_start(core_start), .core_n(core_n), .core_q(core_q),
        .core_done(core_done), .core_out(core_out),
        .core_abort(core_abort), .busy(busy)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [254:0] mock_f(input logic [254:0] n,
                                            input logic [254:0] q);
        return n ^ {q[126:0], q[254:127]} ^ 255'd9;
    endfunction

    function automatic logic [254:0] rnd255();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v[254:0];
    endfunction

    // model state: pending jobs, arbitration pointer, job progress
    bit           pv[R];
    logic [254:0] pn[R];
    logic [254:0] pq[R];
    int           last;
    bit           idle;
    bit           start_due;
    bit           waiting;
    int           wseen;
    int           lat;
    bit           resp_on;
    int           exp_id;
    logic [254:0] exp_out;
    bit           exp_err;
    bit           abort_due;
    logic [254:0] cur_n;
    logic [254:0] cur_q;
    int           grants[$];

    // stimulus knobs
    int req_pct;
    int rdy_pct;
    int drop_pct;
    int force_lat;
    bit allow_hang;

    function automatic int rr_pick();
        for (int i = 1; i <= R; i++) begin
            if (pv[(last + i) % R]) return (last + i) % R;
        end
        return -1;
    endfunction

    task automatic model_reset();
        last      = R - 1;
        idle      = 1'b1;
        start_due = 1'b0;
        waiting   = 1'b0;
        wseen     = 0;
        resp_on   = 1'b0;
        abort_due = 1'b0;
    endtask

    task automatic drive_reqs();
        for (int k = 0; k < R; k++) begin
            req_valid[k]         = pv[k];
            req_n[k*255 +: 255]  = pn[k];
            req_q[k*255 +: 255]  = pq[k];
        end
    endtask

    task automatic cycle();
        int           g;
        logic [R-1:0] er;
        bit           nx_start;
        bit           nx_abort;
        @(negedge clock);
        g  = idle ? rr_pick() : -1;
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        check("req_ready", req_ready, er);
        check("core_start", core_start, start_due);
        if (start_due || waiting) begin
            check("core_n", core_n, cur_n);
            check("core_q", core_q, cur_q);
        end
        check("rsp_valid", rsp_valid, resp_on);
        if (resp_on) begin
            check("rsp_id", rsp_id, exp_id);
            check("rsp_out", rsp_out, exp_out);
            check("rsp_err", rsp_err, exp_err);
        end
        check("core_abort", core_abort, abort_due);
        check("busy", busy, !idle);

        nx_start = 1'b0;
        nx_abort = 1'b0;
        if (resp_on && rsp_ready) begin
            resp_on = 1'b0;
            idle    = 1'b1;
        end
        if (waiting) begin
            if (core_done) begin
                resp_on = 1'b1;
                exp_out = mock_f(cur_n, cur_q);
                exp_err = 1'b0;
                waiting = 1'b0;
            end else begin
                wseen++;
                if (wseen == TO) begin
                    resp_on  = 1'b1;
                    exp_out  = '0;
                    exp_err  = 1'b1;
                    nx_abort = 1'b1;
                    waiting  = 1'b0;
                end
            end
        end
        if (start_due) begin
            waiting = 1'b1;
            wseen   = 0;
            if (force_lat >= 0) lat = force_lat;
            else if (allow_hang && $urandom_range(4) == 0) lat = 100000;
            else if ($urandom_range(7) == 0) lat = TO - 1;
            else lat = $urandom_range(6);
        end
        if (g >= 0) begin
            idle     = 1'b0;
            nx_start = 1'b1;
            cur_n    = pn[g];
            cur_q    = pq[g];
            pv[g]    = 1'b0;
            last     = g;
            exp_id   = g;
            grants.push_back(g);
        end
        start_due = nx_start;
        abort_due = nx_abort;

        @(posedge clock);
        #1;
        core_done = 1'b0;
        core_out  = rnd255();
        if (waiting) begin
            if (wseen == lat) begin
                core_done = 1'b1;
                core_out  = mock_f(core_n, core_q);
            end
        end else if ($urandom_range(5) == 0) begin
            core_done = 1'b1;
        end
        for (int k = 0; k < R; k++) begin
            if (!pv[k] && $urandom_range(99) < req_pct) begin
                pv[k] = 1'b1;
                pn[k] = rnd255();
                pq[k] = rnd255();
            end else if (pv[k] && $urandom_range(99) < drop_pct) begin
                pv[k] = 1'b0;
            end
        end
        drive_reqs();
        rsp_ready = ($urandom_range(99) < rdy_pct);
    endtask

    initial begin
        int base;
        int guard;
        for (int k = 0; k < R; k++) begin
            pv[k] = 1'b0;
            pn[k] = '0;
            pq[k] = '0;
        end
        model_reset();
        force_lat  = 1;
        allow_hang = 1'b0;
        req_pct    = 100;
        rdy_pct    = 100;
        drop_pct   = 0;

        #1;
        check("rst_req_ready", req_ready, '0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_out", rsp_out, 0);
        check("rst_core_n", core_n, 0);
        check("rst_busy", busy, 0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        // all requesters valid: strict rotation from requester 0
        repeat (40) cycle();
        for (int i = 0; i < 5; i++) begin
            check("rr_order", (i < grants.size()) ? grants[i] : -1, i % R);
        end

        // single request from requester 2
        req_pct   = 0;
        force_lat = 2;
        for (int k = 0; k < R; k++) pv[k] = 1'b0;
        pv[2] = 1'b1;
        pn[2] = 255'h1234;
        pq[2] = 255'h5678;
        drive_reqs();
        base = grants.size();
        repeat (20) cycle();
        check("single_grant",
              (grants.size() > base) ? grants[base] : -1, 2);

        // random traffic with back-pressure, hangs and stray done pulses
        req_pct    = 30;
        rdy_pct    = 40;
        drop_pct   = 3;
        force_lat  = -1;
        allow_hang = 1'b1;
        repeat (3000) cycle();

        // reset while waiting on a hung core
        req_pct   = 100;
        rdy_pct   = 100;
        drop_pct  = 0;
        force_lat = 100000;
        guard     = 0;
        while (!start_due && guard < 200) begin
            cycle();
            guard++;
        end
        check("reset_test_start", start_due, 1);
        repeat (6) cycle();
        check("pre_reset_busy", busy, 1);
        for (int k = 0; k < R; k++) pv[k] = 1'b1;
        drive_reqs();
        core_done = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("ar_req_ready", req_ready, '0);
        check("ar_rsp_valid", rsp_valid, 0);
        check("ar_rsp_id", rsp_id, 0);
        check("ar_rsp_out", rsp_out, 0);
        check("ar_rsp_err", rsp_err, 0);
        check("ar_core_start", core_start, 0);
        check("ar_core_n", core_n, 0);
        check("ar_core_q", core_q, 0);
        check("ar_core_abort", core_abort, 0);
        check("ar_busy", busy, 0);
        model_reset();
        reset = 1'b0;
        force_lat = 3;
        base = grants.size();
        repeat (30) cycle();
        check("post_reset_grant",
              (grants.size() > base) ? grants[base] : -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
